// File: rtl/subleq_cpu.sv
// SUBLEQ processor. It runs one instruction: subtract, then branch if the result is <= 0.
// All memory traffic uses a registered req/ack bus, with one idle cycle between accesses.
`ifndef WORD_SIZE
`define WORD_SIZE 8
`endif

module subleq_cpu (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  cpu_req,
    output logic                  cpu_load,
    output logic                  cpu_store,
    output logic [`WORD_SIZE-1:0] addr,
    output logic [`WORD_SIZE-1:0] data_out,
    input  logic                  cpu_ack,
    input  logic [`WORD_SIZE-1:0] data_in,
    input  logic                  cpu_halt,
    output logic                  halted,
    output logic [`WORD_SIZE-1:0] pc
);
    localparam int W = `WORD_SIZE;
    localparam logic [W-1:0] ADDR_HALT = '1;
    localparam logic [W-1:0] ADDR_OUT  = ADDR_HALT - W'(1);
    localparam logic [W-1:0] ADDR_IN   = ADDR_HALT - W'(2);

    typedef enum logic [2:0] {
        IDLE, FETCH_A, FETCH_B, FETCH_C, LOAD_A, LOAD_B, STORE, HALT
    } state_t;

    state_t         state_reg, state_next;
    logic [W-1:0]   pc_reg, pc_next;
    logic           req_reg, req_next;
    logic           load_reg, load_next;
    logic           store_reg, store_next;
    logic [W-1:0]   addr_reg, addr_next;
    logic [W-1:0]   dout_reg, dout_next;
    logic           halted_reg, halted_next;
    logic [W-1:0]   a_ptr_reg, a_ptr_next;
    logic [W-1:0]   b_ptr_reg, b_ptr_next;
    logic [W-1:0]   c_reg, c_next;
    logic [W-1:0]   a_val_reg, a_val_next;
    logic [W-1:0]   b_val_reg, b_val_next;

    logic [W-1:0]   result;
    logic           take_branch;
    logic [W-1:0]   acc_addr;
    logic           is_store;
    logic           skip;
    logic           done;
    logic [W-1:0]   done_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            pc_reg     <= '0;
            req_reg    <= 1'b0;
            load_reg   <= 1'b0;
            store_reg  <= 1'b0;
            addr_reg   <= '0;
            dout_reg   <= '0;
            halted_reg <= 1'b0;
            a_ptr_reg  <= '0;
            b_ptr_reg  <= '0;
            c_reg      <= '0;
            a_val_reg  <= '0;
            b_val_reg  <= '0;
        end else begin
            state_reg  <= state_next;
            pc_reg     <= pc_next;
            req_reg    <= req_next;
            load_reg   <= load_next;
            store_reg  <= store_next;
            addr_reg   <= addr_next;
            dout_reg   <= dout_next;
            halted_reg <= halted_next;
            a_ptr_reg  <= a_ptr_next;
            b_ptr_reg  <= b_ptr_next;
            c_reg      <= c_next;
            a_val_reg  <= a_val_next;
            b_val_reg  <= b_val_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pc_next     = pc_reg;
        req_next    = req_reg;
        load_next   = load_reg;
        store_next  = store_reg;
        addr_next   = addr_reg;
        dout_next   = dout_reg;
        halted_next = halted_reg;
        a_ptr_next  = a_ptr_reg;
        b_ptr_next  = b_ptr_reg;
        c_next      = c_reg;
        a_val_next  = a_val_reg;
        b_val_next  = b_val_reg;
        done        = 1'b0;
        done_val    = '0;

        result      = b_val_reg - a_val_reg;
        take_branch = result[W-1] || (result == '0);

        case (state_reg)
            FETCH_A:       acc_addr = pc_reg;
            FETCH_B:       acc_addr = pc_reg + W'(1);
            FETCH_C:       acc_addr = pc_reg + W'(2);
            LOAD_A:        acc_addr = a_ptr_reg;
            LOAD_B, STORE: acc_addr = b_ptr_reg;
            default:       acc_addr = '0;
        endcase

        // The output port is write-only and the input port is read-only.
        // Accesses the bus cannot serve complete locally in the idle cycle.
        is_store = (state_reg == STORE);
        if (is_store)
            skip = (b_ptr_reg == ADDR_IN);
        else
            skip = (acc_addr == ADDR_OUT) || ((state_reg == LOAD_B) && (b_ptr_reg >= ADDR_IN));

        case (state_reg)
            IDLE: begin
                state_next = FETCH_A;
                req_next   = 1'b1;
                load_next  = 1'b1;
                addr_next  = pc_reg;
            end
            HALT: begin
            end
            default: begin
                if (req_reg) begin
                    // Halt wins over a simultaneous ack; the access is dropped.
                    if (cpu_halt) begin
                        state_next  = HALT;
                        halted_next = 1'b1;
                        req_next    = 1'b0;
                        load_next   = 1'b0;
                        store_next  = 1'b0;
                    end else if (cpu_ack) begin
                        done       = 1'b1;
                        done_val   = data_in;
                        req_next   = 1'b0;
                        load_next  = 1'b0;
                        store_next = 1'b0;
                    end
                end else if (skip) begin
                    done = 1'b1;
                end else begin
                    req_next   = 1'b1;
                    load_next  = !is_store;
                    store_next = is_store;
                    addr_next  = acc_addr;
                    if (is_store)
                        dout_next = result;
                end
            end
        endcase

        if (done) begin
            case (state_reg)
                FETCH_A: begin a_ptr_next = done_val; state_next = FETCH_B; end
                FETCH_B: begin b_ptr_next = done_val; state_next = FETCH_C; end
                FETCH_C: begin c_next     = done_val; state_next = LOAD_A;  end
                LOAD_A:  begin a_val_next = done_val; state_next = LOAD_B;  end
                LOAD_B:  begin b_val_next = done_val; state_next = STORE;   end
                STORE: begin
                    pc_next    = take_branch ? c_reg : pc_reg + W'(3);
                    state_next = FETCH_A;
                end
                default: begin
                end
            endcase
        end
    end

    assign cpu_req   = req_reg;
    assign cpu_load  = load_reg;
    assign cpu_store = store_reg;
    assign addr      = addr_reg;
    assign data_out  = dout_reg;
    assign halted    = halted_reg;
    assign pc        = pc_reg;

endmodule

// File: doc/subleq_cpu.md
SUBLEQ_CPU -- requirements
Module: subleq_cpu

Interface
REQ-001 Parameter: none; all data/address widths SHALL be `WORD_SIZE (W) from defines.vh; addresses MAX=2^W-1 (halt), MAX-1 (output), MAX-2 (input).
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 cpu_req  output  1  bus request.
REQ-005 cpu_load  output  1  request is a read.
REQ-006 cpu_store  output  1  request is a write.
REQ-007 addr  output  W  access address.
REQ-008 data_out  output  W  write data.
REQ-009 cpu_ack  input  1  access complete, sampled on rising edge.
REQ-010 data_in  input  W  read data, valid when cpu_ack=1 on a load.
REQ-011 cpu_halt  input  1  halt condition from the MMIO stage.
REQ-012 halted  output  1  CPU stopped.
REQ-013 pc  output  W  current instruction address (debug).

Function
REQ-014 Each instruction SHALL execute: A=M[pc], B=M[pc+1], C=M[pc+2], a=M[A], b=M[B], r=b-a mod 2^W, M[B]=r; pc=C if r signed <=0, else pc+3 (mod 2^W).
REQ-015 States: IDLE, FETCH_A, FETCH_B, FETCH_C, LOAD_A, LOAD_B, STORE, HALT; order FETCH_A->FETCH_B->FETCH_C->LOAD_A->LOAD_B->STORE->FETCH_A.
REQ-016 cpu_req, cpu_load, cpu_store, addr, data_out SHALL be registered; exactly one of cpu_load/cpu_store high whenever cpu_req=1; both 0 when cpu_req=0.
REQ-017 In a bus state cpu_req and all qualifiers SHALL be held stable until the edge where cpu_ack=1 is sampled; the next cycle SHALL have cpu_req=0 (one idle cycle between accesses).
REQ-018 Read data SHALL be captured from data_in on the same edge cpu_ack=1 is sampled.
REQ-019 A load whose address is MAX-1 SHALL NOT be issued; value taken as 0; only the idle cycle is spent.
REQ-020 A load of b whose address B>=MAX-2 SHALL NOT be issued; b=0 (so output writes -a, input-address stores are skipped).
REQ-021 A store whose address is MAX-2 SHALL NOT be issued; only the idle cycle is spent.
REQ-022 If cpu_halt=1 on any edge while cpu_req=1, the CPU SHALL enter HALT: cpu_req=0 next cycle, halted=1, no further accesses, pc frozen, until rst.
REQ-023 cpu_halt with cpu_req=0 SHALL be ignored; cpu_ack with cpu_req=0 SHALL be ignored.
REQ-024 cpu_halt and cpu_ack both 1 on the same edge: halt SHALL take priority, access data discarded.
REQ-025 pc SHALL update only on the edge completing STORE (or its skip).
REQ-026 With zero-wait ack, an instruction SHALL take 12 cycles from first cpu_req rise to next FETCH_A cpu_req rise; each skipped access removes 1 cycle.
REQ-027 Branch compare SHALL use r as a signed two's-complement W-bit value; r=0 branches.

Reset
REQ-028 While rst=1 at an edge: state=IDLE, pc=0, cpu_req=cpu_load=cpu_store=0, addr=0, data_out=0, halted=0, internal A/B/C/a/b=0.
REQ-029 Reset asserted mid-access SHALL abort it; cpu_req=0 the cycle after; pending ack ignored.
REQ-030 From IDLE after rst deasserts, cpu_req SHALL rise one cycle later in FETCH_A with addr=0.

Verification (W=8)
REQ-031 Reset then release -> cycle 1 IDLE, cycle 2 cpu_req=1, cpu_load=1, addr=0x00, halted=0.
REQ-032 M[0..2]=10,11,9; M[10]=5, M[11]=3 -> store addr 11 data 0xFE, pc=9.
REQ-033 M[0..2]=10,11,9; M[10]=2, M[11]=7 -> store data 0x05, pc=3.
REQ-034 M[0..2]=10,254,3; M[10]=0xBF -> no load at 254, store addr 254 data 0x41, pc=3.
REQ-035 M[0..2]=10,255,0 -> store to 255, cpu_halt=1 -> halted=1, cpu_req=0 forever; rst restores pc=0.
REQ-036 Ack held low 3 cycles on every access -> req/addr/data stable throughout, results as REQ-032, one idle cycle after each ack.
